// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: op encoding, FSM states and op helpers.
package divider_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // DIV and REM treat operands as two's complement; the U variants do not.
  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/divider_step.sv
// UNROLL restoring-division steps, MSB first, on a WIDTH+1 bit partial remainder.
module divider_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic [WIDTH-1:0]  rem_i,
  input  logic [UNROLL-1:0] dvd_i,
  input  logic [WIDTH-1:0]  dvs_i,
  output logic [WIDTH-1:0]  rem_o,
  output logic [UNROLL-1:0] q_o
);

  logic [WIDTH:0] part_c;

  // The carried remainder is always below the divisor, so it fits in WIDTH bits between steps.
  always_comb begin
    part_c = {1'b0, rem_i};
    q_o    = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      part_c = {part_c[WIDTH-1:0], dvd_i[UNROLL-1-i]};
      if (part_c >= {1'b0, dvs_i}) begin
        part_c           = part_c - {1'b0, dvs_i};
        q_o[UNROLL-1-i]  = 1'b1;
      end
    end
    rem_o = part_c[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_pipe_hs.sv
// Iterative DIV/DIVU/REM/REMU unit with valid/ready handshakes, tag, flush and x/0 fast path.
module divider_pipe_hs
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [WIDTH-1:0]  req_a_i,
  input  logic [WIDTH-1:0]  req_b_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WIDTH-1:0]  resp_value_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              busy_o
);

  localparam int unsigned K     = WIDTH / UNROLL;
  localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned QH_W  = WIDTH - UNROLL;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              is_rem_q;
  logic              inv_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WIDTH-1:0]  dvd_q, dvs_q, rem_q, value_q;
  logic [QH_W-1:0]   quot_q;
  logic [TAG_W-1:0]  resp_tag_q;

  logic              accept_c, last_c, b_zero_c, inv_c;
  logic [WIDTH-1:0]  a_mag_c, b_mag_c, rem_nxt_c, quot_nxt_c, res_c;
  logic [UNROLL-1:0] qbits_c;

  divider_step #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q[WIDTH-1 -: UNROLL]),
    .dvs_i (dvs_q),
    .rem_o (rem_nxt_c),
    .q_o   (qbits_c)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush wins over every transition
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept_c) state_d = b_zero_c ? DONE : BUSY;
        BUSY:    if (last_c) state_d = DONE;
        DONE:    if (resp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    req_ready_o  = (state_q == IDLE) && !flush_i;
    resp_valid_o = (state_q == DONE);
    busy_o       = (state_q != IDLE);
    accept_c     = req_valid_i && (state_q == IDLE) && !flush_i;
  end

  // Operand conditioning at accept: magnitudes and the result sign correction
  always_comb begin
    b_zero_c = (req_b_i == '0);
    a_mag_c  = (is_signed_op(req_op_i) && req_a_i[WIDTH-1]) ? -req_a_i : req_a_i;
    b_mag_c  = (is_signed_op(req_op_i) && req_b_i[WIDTH-1]) ? -req_b_i : req_b_i;
    inv_c    = 1'b0;
    if (req_op_i == OP_DIV)      inv_c = (req_a_i[WIDTH-1] != req_b_i[WIDTH-1]) && !b_zero_c;
    else if (req_op_i == OP_REM) inv_c = req_a_i[WIDTH-1];
  end

  always_comb begin
    last_c     = (cnt_q == CNT_W'(K - 1));
    quot_nxt_c = {quot_q, qbits_c};
    res_c      = is_rem_q ? rem_nxt_c : quot_nxt_c;
  end

  // Datapath; the final step result is corrected and registered on the way into DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      is_rem_q   <= 1'b0;
      inv_q      <= 1'b0;
      tag_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      value_q    <= '0;
      resp_tag_q <= '0;
    end else if (accept_c) begin
      is_rem_q <= req_op_i[1];
      inv_q    <= inv_c;
      tag_q    <= req_tag_i;
      dvd_q    <= a_mag_c;
      dvs_q    <= b_mag_c;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      if (b_zero_c) begin
        value_q    <= req_op_i[1] ? req_a_i : '1;
        resp_tag_q <= req_tag_i;
      end
    end else if (state_q == BUSY && !flush_i) begin
      rem_q  <= rem_nxt_c;
      dvd_q  <= dvd_q << UNROLL;
      quot_q <= quot_nxt_c[QH_W-1:0];
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last_c) begin
        value_q    <= inv_q ? -res_c : res_c;
        resp_tag_q <= tag_q;
      end
    end
  end

  assign resp_value_o = value_q;
  assign resp_tag_o   = resp_tag_q;

endmodule

// File: tb/tb_divider_pipe_hs.sv
// Bench for divider_pipe_hs: directed RISC-V cases on a 32/1 instance plus a random sweep over six configurations.
module tb_divider_pipe_hs;

  localparam int NCFG = 6;
  localparam int CW [NCFG] = '{32, 32, 32, 16, 16, 16};
  localparam int CU [NCFG] = '{1, 2, 4, 1, 2, 4};

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid  [NCFG];
  logic        req_ready  [NCFG];
  logic [1:0]  req_op     [NCFG];
  logic [31:0] req_a      [NCFG];
  logic [31:0] req_b      [NCFG];
  logic [4:0]  req_tag    [NCFG];
  logic        flush      [NCFG];
  logic        resp_valid [NCFG];
  logic        resp_ready [NCFG];
  logic [31:0] resp_value [NCFG];
  logic [4:0]  resp_tag   [NCFG];
  logic        busy       [NCFG];

  int n_vec = 0;
  int n_err = 0;
  int n_ops = 0;
  int cyc   = 0;

  // Model state: one outstanding operation per configuration
  bit          pend    [NCFG];
  logic [31:0] exp_val [NCFG];
  logic [4:0]  exp_tag [NCFG];
  int          acc_cyc [NCFG];
  int          exp_lat [NCFG];
  bit          rst_prev;

  bit          dir_en;
  logic [31:0] dir_exp;
  int          dir_lat;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned W = CW[g];
    localparam int unsigned U = CU[g];
    logic [W-1:0] v;
    divider_pipe_hs #(.WIDTH(W), .UNROLL(U), .TAG_W(5)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_op_i     (req_op[g]),
      .req_a_i      (req_a[g][W-1:0]),
      .req_b_i      (req_b[g][W-1:0]),
      .req_tag_i    (req_tag[g]),
      .flush_i      (flush[g]),
      .resp_valid_o (resp_valid[g]),
      .resp_ready_i (resp_ready[g]),
      .resp_value_o (v),
      .resp_tag_o   (resp_tag[g]),
      .busy_o       (busy[g])
    );
    assign resp_value[g] = 32'(v);
  end

  // RISC-V division semantics in wide signed arithmetic
  function automatic logic [31:0] ref_div(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint m, ua, ub, sa, sb, r;
    m  = (longint'(1) <<< w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (ua > (m >>> 1)) ? ua - (m + 1) : ua;
    sb = (ub > (m >>> 1)) ? ub - (m + 1) : ub;
    if (ub == 0)       r = op[1] ? ua : m;
    else if (op == DIV)  r = sa / sb;
    else if (op == REM)  r = sa % sb;
    else if (op == DIVU) r = ua / ub;
    else                 r = ua % ub;
    return 32'(r & m);
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s cfg%0d cyc%0d: got %h want %h", nm, c, cyc, got, want);
    end
  endtask

  // Compare process: every cycle, check all outputs against the model, then advance the model
  initial begin
    bit ev, er;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCFG; c++) begin
        ev = pend[c] && (cyc - acc_cyc[c] >= exp_lat[c]);
        er = !pend[c] && !flush[c];
        chk("resp_valid", c, 32'(resp_valid[c]), 32'(ev));
        chk("req_ready",  c, 32'(req_ready[c]),  32'(er));
        chk("busy",       c, 32'(busy[c]),       32'(pend[c]));
        if (ev) begin
          chk("resp_value", c, resp_value[c], exp_val[c]);
          chk("resp_tag",   c, 32'(resp_tag[c]), 32'(exp_tag[c]));
        end
        if (rst_prev) begin
          chk("reset value", c, resp_value[c], 32'd0);
          chk("reset tag",   c, 32'(resp_tag[c]), 32'd0);
        end
        if (rst) pend[c] = 1'b0;
        else if (flush[c]) pend[c] = 1'b0;
        else if (ev && resp_ready[c]) pend[c] = 1'b0;
        else if (req_valid[c] && er) begin
          pend[c]    = 1'b1;
          acc_cyc[c] = cyc;
          exp_val[c] = ref_div(CW[c], req_op[c], req_a[c], req_b[c]);
          exp_tag[c] = req_tag[c];
          exp_lat[c] = (req_b[c] == 32'd0) ? 1 : CW[c] / CU[c] + 1;
          n_ops++;
          if (c == 0 && dir_en) begin
            chk("model value",   0, exp_val[0], dir_exp);
            chk("model latency", 0, 32'(exp_lat[0]), 32'(dir_lat));
          end
        end
      end
      rst_prev = rst;
    end
  end

  task automatic wait_pend(input bit want, input int lim);
    int n = 0;
    while (pend[0] != want) begin
      @(posedge clk); #1;
      n++;
      if (n > lim) begin
        $display("FAIL wait cfg0: pend still %0d after %0d cycles", pend[0], lim);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] dexp, input int dlat, input int hold);
    dir_en        = 1'b1;
    dir_exp       = dexp;
    dir_lat       = dlat;
    req_valid[0]  = 1'b1;
    req_op[0]     = op;
    req_a[0]      = a;
    req_b[0]      = b;
    req_tag[0]    = tag;
    resp_ready[0] = (hold == 0);
    wait_pend(1'b1, 20);
    req_valid[0] = 1'b0;
    dir_en       = 1'b0;
    if (hold > 0) begin
      repeat (dlat + hold) @(posedge clk);
      #1 resp_ready[0] = 1'b1;
    end
    wait_pend(1'b0, 100);
  endtask

  initial begin
    int sel;
    logic [31:0] m, mn;
    rst = 1'b1;
    dir_en = 1'b0; dir_exp = '0; dir_lat = 0;
    for (int c = 0; c < NCFG; c++) begin
      req_valid[c] = 1'b0; req_op[c] = DIVU; req_a[c] = '0; req_b[c] = '0;
      req_tag[c] = '0; flush[c] = 1'b0; resp_ready[c] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, 0);
    issue(REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33, 0);
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 0);
    issue(REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0);
    issue(DIV,  32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 33, 0);
    issue(REM,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 33, 0);
    issue(DIV,  32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 0);
    issue(REM,  32'd5, 32'd0, 5'd10, 32'd5, 1, 0);
    issue(DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 0);
    issue(REMU, 32'd5, 32'd0, 5'd12, 32'd5, 1, 0);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 33, 0);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 33, 0);
    issue(DIVU, 32'd1000, 32'd10, 5'd15, 32'd100, 33, 10);

    // Flush twelve cycles into BUSY with a competing request
    req_valid[0] = 1'b1; req_op[0] = DIVU; req_a[0] = 32'd1000; req_b[0] = 32'd7; req_tag[0] = 5'd16;
    wait_pend(1'b1, 20);
    req_valid[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush[0] = 1'b1; req_valid[0] = 1'b1; req_op[0] = DIV; req_a[0] = 32'd50; req_b[0] = 32'd5;
    @(posedge clk); #1;
    flush[0] = 1'b0; req_valid[0] = 1'b0;
    issue(DIVU, 32'd9, 32'd3, 5'd17, 32'd3, 33, 0);

    // Reset in the middle of an operation
    req_valid[0] = 1'b1; req_op[0] = DIV; req_a[0] = 32'd77; req_b[0] = 32'd5; req_tag[0] = 5'd18;
    wait_pend(1'b1, 20);
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 5'd19, 32'd14, 33, 0);

    // Random sweep across all configurations in parallel
    repeat (25000) begin
      @(posedge clk); #1;
      for (int c = 0; c < NCFG; c++) begin
        m  = (CW[c] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        mn = 32'(1) << (CW[c] - 1);
        req_valid[c] = ($urandom_range(0, 7) != 0);
        req_op[c]    = 2'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      req_a[c] = mn;
        else if (sel == 1) req_a[c] = '0;
        else               req_a[c] = ($urandom >> $urandom_range(0, 31)) & m;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      req_b[c] = '0;
        else if (sel == 1) req_b[c] = m;
        else               req_b[c] = ($urandom >> $urandom_range(0, 31)) & m;
        req_tag[c]    = 5'($urandom);
        resp_ready[c] = ($urandom_range(0, 3) != 0);
        flush[c]      = ($urandom_range(0, 299) == 0);
      end
    end
    for (int c = 0; c < NCFG; c++) begin
      req_valid[c] = 1'b0; flush[c] = 1'b0; resp_ready[c] = 1'b1;
    end
    repeat (40) @(posedge clk);
    #1;
    $display("operations accepted: %0d", n_ops);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
